uart_wb_echo_ctrl: RTL and testbench
====================================

# uart_wb_echo_ctrl

Wishbone master that brings up the 16550-compatible `uart_top` core and then runs it as a byte echo engine. It sits directly upstream of `uart_top` on its Wishbone slave port, in the Tiny Tapeout top. After reset it programs the divisor latch, line control and FIFO control registers. It then loops forever: poll LSR for received data, read RBR, wait for THRE, write the byte back to THR. Status outputs (init done, echo count, last byte, bus error) are intended for `uo_out`.

## Interface
Parameters:
- `DIVISOR`, 16'd27, baud divisor written to DLL/DLM (clk / (16 × baud)).
- `ACK_TIMEOUT`, 15, maximum cycles a strobe may wait for `wb_ack_i` before abort.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `wb_adr_o` out 3: UART register address (8-bit data bus mode).
- `wb_dat_o` out 8: write data.
- `wb_dat_i` in 8: read data.
- `wb_we_o` out 1: 1 = write.
- `wb_stb_o` out 1: strobe.
- `wb_cyc_o` out 1: cycle; always equal to `wb_stb_o`.
- `wb_sel_o` out 4: constant 4'b1111.
- `wb_ack_i` in 1: slave acknowledge.
- `init_done` out 1: register bring-up complete.
- `echo_cnt` out 8: bytes echoed, wraps 255→0.
- `last_byte` out 8: most recent byte written to THR.
- `bus_err` out 1: sticky, set on any ack timeout.

## Operation
- Init sequence, one write each, in this order:
  - LCR(3) ← 0x83 (DLAB=1, 8N1)
  - DLL(0) ← DIVISOR[7:0]
  - DLM(1) ← DIVISOR[15:8]
  - LCR(3) ← 0x03
  - FCR(2) ← 0x07
  - IER(1) ← 0x00
- `init_done` rises in the cycle after the IER ack.
- Echo loop:
  - POLL_RX: read LSR(5). If bit0 (DR) = 0, repeat POLL_RX; else go to READ_RBR.
  - READ_RBR: read addr 0 and latch the byte.
  - POLL_TX: read LSR. If bit5 (THRE) = 0, repeat POLL_TX; else go to WRITE_THR.
  - WRITE_THR: write the latched byte to addr 0. On ack, update `last_byte` and do `echo_cnt` += 1, then return to POLL_RX.
- Timeout: a timeout during any access sets `bus_err`, clears `init_done` and restarts the init sequence at LCR ← 0x83. `echo_cnt` and `last_byte` are kept.
- Reset values:
  - all Wishbone outputs 0, except `wb_sel_o` = 4'b1111
  - `init_done` = 0, `bus_err` = 0, `echo_cnt` = 0x00, `last_byte` = 0x00
  - FSM enters the first init write.

## Timing
- All outputs are registered.
- Access issue: `wb_cyc_o`/`wb_stb_o`/`wb_adr_o`/`wb_we_o`/`wb_dat_o` assert in the cycle after the FSM enters an access state. They stay stable until the edge at which `wb_ack_i` = 1 is sampled.
- Read data is captured on that same edge.
- `wb_stb_o` = 0 for at least one full cycle between consecutive accesses. Minimum access period is 3 cycles with a 1-cycle ack.
- `wb_ack_i` is ignored while `wb_stb_o` = 0.
- Timeout counter: counts cycles with stb = 1 and ack = 0. When it reaches `ACK_TIMEOUT`, stb drops on the next edge. An ack arriving on that same edge wins (access completes normally, no error).
- `rst_n` low mid-access: stb/cyc are 0 after the sampling edge and the in-flight access is abandoned.
- `echo_cnt` increments on the WRITE_THR ack edge and is visible the next cycle.

## Configuration
- `UART_ECHO_UPCASE_EN` defined: bytes 0x61–0x7A have bit5 cleared before the THR write, and `last_byte` reflects the converted value.
- Not defined: bytes are echoed unmodified.

## Structure
- `uart_echo_pkg`:
  - register address constants (RBR_THR=0, IER=1, FCR=2, LCR=3, LSR=5)
  - LCR/FCR/IER init values and LSR bit indices
  - FSM state enum
- One sub-module, `wb_single_access`: a single-access Wishbone engine.
  - Inputs: `req`, `we`, `adr`, `wdat`.
  - Outputs: `done`, `rdat`, `timeout`.
  - Owns stb/cyc, the idle gap and the timeout counter.
  - The top FSM only sequences requests.

## Test plan
- Bring-up with a slave model that acks after 1 cycle → exactly 6 writes (3←0x83, 0←0x1B, 1←0x00, 3←0x03, 2←0x07, 1←0x00); `init_done` = 1 the next cycle.
- LSR returns 0x60 for 4 polls, then 0x61 with RBR = 0x41 → read RBR, one LSR poll, THR ← 0x41, `echo_cnt` = 1, `last_byte` = 0x41.
- After RBR read, LSR returns 0x01 (THRE = 0) for 10 polls → no THR write until 0x21 is returned.
- Slave never acks the DLM write → stb drops after 15 cycles, `bus_err` = 1, sequence restarts at LCR ← 0x83.
- 256 echoes → `echo_cnt` wraps to 0x00. With `UART_ECHO_UPCASE_EN`, RBR = 0x7A → THR ← 0x5A; without it → THR ← 0x7A.
- `rst_n` low during a stalled LSR read → stb = 0 the next cycle, all outputs at reset values, init restarts after release.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// -----------------------------------------------------------------------------
// uart_echo_pkg
// Shared definitions for the UART echo controller:
//   - 16550 register addresses (8-bit data bus mode)
//   - bring-up values for LCR / FCR / IER and LSR bit positions
//   - top-level FSM state enum
//   - to_upper(): ASCII lower-to-upper helper used when the optional
//     upcase feature (UART_ECHO_UPCASE_EN) is compiled in
// -----------------------------------------------------------------------------
package uart_echo_pkg;

    // Register addresses. DLL/DLM alias RBR_THR/IER while LCR.DLAB = 1.
    localparam logic [2:0] ADR_RBR_THR = 3'd0;
    localparam logic [2:0] ADR_DLL     = 3'd0;
    localparam logic [2:0] ADR_IER     = 3'd1;
    localparam logic [2:0] ADR_DLM     = 3'd1;
    localparam logic [2:0] ADR_FCR     = 3'd2;
    localparam logic [2:0] ADR_LCR     = 3'd3;
    localparam logic [2:0] ADR_LSR     = 3'd5;

    // Bring-up register values
    localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;  // DLAB=1, 8 data, no parity, 1 stop
    localparam logic [7:0] LCR_8N1      = 8'h03;  // DLAB=0, 8N1
    localparam logic [7:0] FCR_INIT     = 8'h07;  // enable FIFOs, clear RX/TX FIFOs
    localparam logic [7:0] IER_INIT     = 8'h00;  // all interrupts masked

    // LSR bit positions
    localparam int LSR_DR_BIT   = 0;  // receive data ready
    localparam int LSR_THRE_BIT = 5;  // transmit holding register empty

    typedef enum logic [3:0] {
        ST_INIT_LCR_DLAB = 4'd0,
        ST_INIT_DLL      = 4'd1,
        ST_INIT_DLM      = 4'd2,
        ST_INIT_LCR      = 4'd3,
        ST_INIT_FCR      = 4'd4,
        ST_INIT_IER      = 4'd5,
        ST_POLL_RX       = 4'd6,
        ST_READ_RBR      = 4'd7,
        ST_POLL_TX       = 4'd8,
        ST_WRITE_THR     = 4'd9
    } echo_state_t;

    // Clear bit5 of ASCII 'a'..'z'; every other byte passes unchanged.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = b & 8'hDF;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_wb_echo_ctrl_wb_single_access.sv
// -----------------------------------------------------------------------------
// wb_single_access
// Single-access Wishbone master engine (classic cycles, one access at a time).
// Owns stb/cyc, the mandatory idle gap between accesses and the ack timeout.
//
// Handshake with the sequencer: while the engine is idle and `req` is high it
// latches we/adr/wdat and raises stb/cyc on the next edge. `done` is a
// one-cycle pulse that is high exactly in the cycle whose closing edge samples
// wb_ack_i = 1 (rdat is valid in that same cycle, so the sequencer captures
// read data on the ack edge). `timeout` is a one-cycle pulse in the cycle whose
// closing edge abandons the access. After either, stb stays low for one full
// gap cycle before a new `req` is accepted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req, we, adr, wdat    access request from the sequencer
//   done, rdat, timeout   completion / read data / abort
//   wb_*                  Wishbone master signals (8-bit data bus)
// -----------------------------------------------------------------------------
module wb_single_access #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] wdat,
    output logic       done,
    output logic [7:0] rdat,
    output logic       timeout,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_BUSY = 2'd1,
        ACC_GAP  = 2'd2
    } acc_state_t;

    acc_state_t    r_state;
    logic          r_stb;
    logic          r_we;
    logic [2:0]    r_adr;
    logic [7:0]    r_dat;
    logic [CW-1:0] r_cnt;

    logic w_ack;
    logic w_expire;

    // Ack only counts while the strobe is up.
    assign w_ack    = r_stb & wb_ack_i;
    // r_cnt holds the number of already-elapsed unacked strobe cycles, so the
    // access is abandoned at the edge closing the ACK_TIMEOUT-th such cycle.
    // An ack on that same edge takes priority.
    assign w_expire = r_stb & ~wb_ack_i & (r_cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACC_IDLE;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 3'd0;
            r_dat   <= 8'h00;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ACC_IDLE: begin
                    if (req) begin
                        r_stb   <= 1'b1;
                        r_we    <= we;
                        r_adr   <= adr;
                        r_dat   <= wdat;
                        r_cnt   <= '0;
                        r_state <= ACC_BUSY;
                    end
                end
                ACC_BUSY: begin
                    if (w_ack || w_expire) begin
                        r_stb   <= 1'b0;
                        r_state <= ACC_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ACC_GAP: begin
                    r_state <= ACC_IDLE;
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_state <= ACC_IDLE;
                end
            endcase
        end
    end

    assign done     = w_ack;
    assign timeout  = w_expire;
    assign rdat     = wb_dat_i;
    assign wb_stb_o = r_stb;
    assign wb_cyc_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;

endmodule

// File: rtl/uart_wb_echo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_wb_echo_ctrl
// Wishbone master that brings up a 16550-compatible UART and then echoes every
// received byte back to the transmitter.
//
// Bring-up: LCR<-0x83, DLL<-DIVISOR[7:0], DLM<-DIVISOR[15:8], LCR<-0x03,
//           FCR<-0x07, IER<-0x00. Echo loop: poll LSR.DR, read RBR, poll
//           LSR.THRE, write THR. Any ack timeout sets the sticky bus_err,
//           drops init_done and restarts bring-up (echo_cnt/last_byte kept).
//
// Compile-time option: UART_ECHO_UPCASE_EN -- when defined, received bytes
// 'a'..'z' are converted to upper case before being echoed (and last_byte
// shows the converted value). Undefined: bytes are echoed unmodified.
//
// Parameters: DIVISOR (baud divisor), ACK_TIMEOUT (max unacked strobe cycles)
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   wb_*             Wishbone master to uart_top (8-bit data bus mode)
//   init_done        bring-up complete
//   echo_cnt         bytes echoed (wraps)
//   last_byte        most recent byte written to THR
//   bus_err          sticky ack-timeout flag
//   dbg_state        current FSM state (echo_state_t encoding)
// -----------------------------------------------------------------------------
module uart_wb_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    output logic       init_done,
    output logic [7:0] echo_cnt,
    output logic [7:0] last_byte,
    output logic       bus_err,
    output logic [3:0] dbg_state
);

    echo_state_t r_state;
    logic [7:0]  r_rx_byte;
    logic        r_init_done;
    logic [7:0]  r_echo_cnt;
    logic [7:0]  r_last_byte;
    logic        r_bus_err;

    logic        w_req;
    logic        w_we;
    logic [2:0]  w_adr;
    logic [7:0]  w_wdat;
    logic        w_done;
    logic        w_timeout;
    logic [7:0]  w_rdat;
    logic [7:0]  w_rx_conv;

    // Every state performs exactly one access; the engine's idle/gap states
    // decide when the next one actually starts.
    assign w_req = 1'b1;

    // Access descriptor for the current state.
    always_comb begin
        w_we   = 1'b0;
        w_adr  = ADR_LSR;
        w_wdat = 8'h00;
        case (r_state)
            ST_INIT_LCR_DLAB: begin w_we = 1'b1; w_adr = ADR_LCR; w_wdat = LCR_DLAB_8N1;   end
            ST_INIT_DLL:      begin w_we = 1'b1; w_adr = ADR_DLL; w_wdat = DIVISOR[7:0];   end
            ST_INIT_DLM:      begin w_we = 1'b1; w_adr = ADR_DLM; w_wdat = DIVISOR[15:8];  end
            ST_INIT_LCR:      begin w_we = 1'b1; w_adr = ADR_LCR; w_wdat = LCR_8N1;        end
            ST_INIT_FCR:      begin w_we = 1'b1; w_adr = ADR_FCR; w_wdat = FCR_INIT;       end
            ST_INIT_IER:      begin w_we = 1'b1; w_adr = ADR_IER; w_wdat = IER_INIT;       end
            ST_POLL_RX:       begin w_adr = ADR_LSR;                                       end
            ST_READ_RBR:      begin w_adr = ADR_RBR_THR;                                   end
            ST_POLL_TX:       begin w_adr = ADR_LSR;                                       end
            ST_WRITE_THR:     begin w_we = 1'b1; w_adr = ADR_RBR_THR; w_wdat = r_rx_byte;  end
            default:          begin w_adr = ADR_LSR;                                       end
        endcase
    end

`ifdef UART_ECHO_UPCASE_EN
    assign w_rx_conv = to_upper(w_rdat);
`else
    assign w_rx_conv = w_rdat;
`endif

    wb_single_access #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_access (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (w_req),
        .we       (w_we),
        .adr      (w_adr),
        .wdat     (w_wdat),
        .done     (w_done),
        .rdat     (w_rdat),
        .timeout  (w_timeout),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

    // Sequencer: advances only on the edge that completes or aborts an access,
    // so read data and status updates are taken on the ack edge itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_INIT_LCR_DLAB;
            r_rx_byte   <= 8'h00;
            r_init_done <= 1'b0;
            r_echo_cnt  <= 8'h00;
            r_last_byte <= 8'h00;
            r_bus_err   <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err   <= 1'b1;
            r_init_done <= 1'b0;
            r_state     <= ST_INIT_LCR_DLAB;
        end else if (w_done) begin
            case (r_state)
                ST_INIT_LCR_DLAB: r_state <= ST_INIT_DLL;
                ST_INIT_DLL:      r_state <= ST_INIT_DLM;
                ST_INIT_DLM:      r_state <= ST_INIT_LCR;
                ST_INIT_LCR:      r_state <= ST_INIT_FCR;
                ST_INIT_FCR:      r_state <= ST_INIT_IER;
                ST_INIT_IER: begin
                    r_init_done <= 1'b1;
                    r_state     <= ST_POLL_RX;
                end
                ST_POLL_RX: begin
                    if (w_rdat[LSR_DR_BIT]) begin
                        r_state <= ST_READ_RBR;
                    end
                end
                ST_READ_RBR: begin
                    r_rx_byte <= w_rx_conv;
                    r_state   <= ST_POLL_TX;
                end
                ST_POLL_TX: begin
                    if (w_rdat[LSR_THRE_BIT]) begin
                        r_state <= ST_WRITE_THR;
                    end
                end
                ST_WRITE_THR: begin
                    r_last_byte <= r_rx_byte;
                    r_echo_cnt  <= r_echo_cnt + 8'd1;
                    r_state     <= ST_POLL_RX;
                end
                default: r_state <= ST_INIT_LCR_DLAB;
            endcase
        end
    end

    assign wb_sel_o  = 4'b1111;
    assign init_done = r_init_done;
    assign echo_cnt  = r_echo_cnt;
    assign last_byte = r_last_byte;
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_wb_echo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_echo_ctrl
// Self-checking bench for uart_wb_echo_ctrl. A behavioural 16550 slave model
// answers LSR/RBR reads from queues filled by the directed steps; every acked
// access it sees is logged and compared in order against the access list the
// bench predicts from the register-level description of bring-up and echo.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_wb_echo_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT ----------------
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       wb_ack_i;
    logic       init_done;
    logic [7:0] echo_cnt;
    logic [7:0] last_byte;
    logic       bus_err;
    logic [3:0] dbg_state;

    uart_wb_echo_ctrl #(
        .DIVISOR     (16'd27),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_sel_o  (wb_sel_o),
        .wb_ack_i  (wb_ack_i),
        .init_done (init_done),
        .echo_cnt  (echo_cnt),
        .last_byte (last_byte),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    // ---------------- slave model ----------------
    logic [7:0]  lsr_q[$];
    logic [7:0]  rbr_q[$];
    int          ack_lat   = 0;
    logic        stall_en  = 1'b0;
    logic        stall_we  = 1'b0;
    logic [2:0]  stall_adr = 3'd0;
    int          wait_n    = 0;
    logic        cur_dflt  = 1'b0;

    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
    end

    // Ack after ack_lat waiting cycles; data for reads chosen when ack rises.
    // Reads of an empty queue return an idle value and are marked default.
    always @(negedge clk) begin
        if (wb_stb_o && !(stall_en && (wb_we_o == stall_we) && (wb_adr_o == stall_adr))) begin
            if (wait_n >= ack_lat) begin
                cur_dflt = 1'b0;
                wb_dat_i = 8'h00;
                if (!wb_we_o && (wb_adr_o == 3'd5)) begin
                    if (lsr_q.size() > 0) wb_dat_i = lsr_q.pop_front();
                    else begin wb_dat_i = 8'h60; cur_dflt = 1'b1; end
                end else if (!wb_we_o && (wb_adr_o == 3'd0)) begin
                    if (rbr_q.size() > 0) wb_dat_i = rbr_q.pop_front();
                    else cur_dflt = 1'b1;
                end
                wb_ack_i = 1'b1;
            end else begin
                wait_n++;
            end
        end else begin
            wb_ack_i = 1'b0;
            wait_n   = 0;
        end
    end

    // Completed-access log: {we, adr, data}
    logic [11:0] act_q[$];
    int          n_wr = 0;
    always @(posedge clk) begin
        if (rst_n && wb_stb_o && wb_ack_i) begin
            if (wb_we_o) n_wr++;
            if (!cur_dflt) act_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
        end
    end

    // ---------------- scoreboard / model ----------------
    logic [11:0] exp_q[$];
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [7:0]  m_cnt   = 8'h00;
    logic [7:0]  m_last  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ent(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        return {we, adr, dat};
    endfunction

    // Byte the UART should see on THR for a received byte.
    function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic push_init();
        exp_q.push_back(ent(1'b1, 3'd3, 8'h83));
        exp_q.push_back(ent(1'b1, 3'd0, 8'h1B));
        exp_q.push_back(ent(1'b1, 3'd1, 8'h00));
        exp_q.push_back(ent(1'b1, 3'd3, 8'h03));
        exp_q.push_back(ent(1'b1, 3'd2, 8'h07));
        exp_q.push_back(ent(1'b1, 3'd1, 8'h00));
    endtask

    task automatic sb_drain(input string tag);
        logic [11:0] a, e;
        check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_access"}, 32'(a), 32'(e));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stb"},   32'(wb_stb_o),  32'(0));
        check({tag, "_cyc"},   32'(wb_cyc_o),  32'(0));
        check({tag, "_adr"},   32'(wb_adr_o),  32'(0));
        check({tag, "_we"},    32'(wb_we_o),   32'(0));
        check({tag, "_dat"},   32'(wb_dat_o),  32'(0));
        check({tag, "_sel"},   32'(wb_sel_o),  32'hF);
        check({tag, "_init"},  32'(init_done), 32'(0));
        check({tag, "_err"},   32'(bus_err),   32'(0));
        check({tag, "_cnt"},   32'(echo_cnt),  32'(0));
        check({tag, "_last"},  32'(last_byte), 32'(0));
    endtask

    // Waits for six bring-up writes; init_done must be up the cycle after the last.
    task automatic wait_init(input string tag);
        int base;
        base = n_wr;
        for (int i = 0; i < 400 && (n_wr - base) < 6; i++) @(negedge clk);
        check({tag, "_init_done"}, 32'(init_done), 32'(1));
        sb_drain(tag);
    endtask

    task automatic do_echo(input logic [7:0] b, input int n_dr0, input int n_thre0, input int lat);
        ack_lat = lat;
        for (int i = 0; i < n_dr0; i++) begin
            lsr_q.push_back(8'h60);
            exp_q.push_back(ent(1'b0, 3'd5, 8'h60));
        end
        lsr_q.push_back(8'h61);
        exp_q.push_back(ent(1'b0, 3'd5, 8'h61));
        rbr_q.push_back(b);
        exp_q.push_back(ent(1'b0, 3'd0, b));
        for (int i = 0; i < n_thre0; i++) begin
            lsr_q.push_back(8'h01);
            exp_q.push_back(ent(1'b0, 3'd5, 8'h01));
        end
        lsr_q.push_back(8'h21);
        exp_q.push_back(ent(1'b0, 3'd5, 8'h21));
        exp_q.push_back(ent(1'b1, 3'd0, echo_of(b)));
        m_cnt  = m_cnt + 8'd1;
        m_last = echo_of(b);
        for (int i = 0; i < 2000 && echo_cnt != m_cnt; i++) @(negedge clk);
        check("echo_cnt", 32'(echo_cnt), 32'(m_cnt));
        check("last_byte", 32'(last_byte), 32'(m_last));
        sb_drain("echo");
    endtask

    // Measures how many cycles a stalled strobe stays up (first cycle included).
    task automatic count_stall(output int n_hi);
        n_hi = 0;
        while (wb_stb_o && n_hi < 100) begin
            n_hi++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_hi;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Bring-up with immediate ack
        push_init();
        rst_n = 1'b1;
        wait_init("bringup");

        // LSR not ready for 4 polls, then 'A'
        do_echo(8'h41, 4, 0, 0);
        // THRE low for 10 polls before the THR write
        do_echo(8'($urandom_range(0, 255)), 0, 10, 1);
        // lower-case 'z'
        do_echo(8'h7A, 1, 1, 0);
        // random traffic up to 256 echoes in total
        for (int i = 3; i < 256; i++) begin
            do_echo(8'($urandom_range(0, 255)), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end
        check("echo_cnt_wrap", 32'(echo_cnt), 32'h00);
        do_echo(8'($urandom_range(0, 255)), 0, 0, 0);

        // Stalled LSR poll in the echo loop: timeout, counters kept, re-init
        ack_lat   = 0;
        stall_we  = 1'b0;
        stall_adr = 3'd5;
        stall_en  = 1'b1;
        push_init();
        for (int i = 0; i < 50 && wb_stb_o; i++) @(negedge clk);
        for (int i = 0; i < 50 && !wb_stb_o; i++) @(negedge clk);
        count_stall(n_hi);
        check("lsr_timeout_cycles", 32'(n_hi), 32'(15));
        check("lsr_timeout_bus_err", 32'(bus_err), 32'(1));
        check("lsr_timeout_init_low", 32'(init_done), 32'(0));
        check("lsr_timeout_cnt_kept", 32'(echo_cnt), 32'(m_cnt));
        check("lsr_timeout_last_kept", 32'(last_byte), 32'(m_last));
        stall_en = 1'b0;
        wait_init("reinit");

        // Reset during a stalled LSR read
        stall_en = 1'b1;
        for (int i = 0; i < 50 && wb_stb_o; i++) @(negedge clk);
        for (int i = 0; i < 50 && !wb_stb_o; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("stall_stb_held", 32'(wb_stb_o), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        m_cnt  = 8'h00;
        m_last = 8'h00;
        stall_en = 1'b0;
        act_q.delete();
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("post_reset");
        do_echo(8'($urandom_range(0, 255)), 1, 0, 0);

        // DLM write never acked
        stall_we  = 1'b1;
        stall_adr = 3'd1;
        stall_en  = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        act_q.delete();
        m_cnt  = 8'h00;
        m_last = 8'h00;
        exp_q.push_back(ent(1'b1, 3'd3, 8'h83));
        exp_q.push_back(ent(1'b1, 3'd0, 8'h1B));
        rst_n = 1'b1;
        for (int i = 0; i < 100 && !(wb_stb_o && wb_we_o && wb_adr_o == 3'd1); i++) @(negedge clk);
        count_stall(n_hi);
        check("dlm_timeout_cycles", 32'(n_hi), 32'(15));
        check("dlm_timeout_bus_err", 32'(bus_err), 32'(1));
        check("dlm_timeout_init_low", 32'(init_done), 32'(0));
        sb_drain("dlm_prefix");
        stall_en = 1'b0;
        push_init();
        wait_init("dlm_restart");
        check("bus_err_sticky", 32'(bus_err), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
